// File: rtl/uart_ram_dumper.sv
// uart_ram_dumper: reads 32-bit words from RAM and sends each as four 8N1 bytes, LSB byte first.
// Optional feature macro UART_DUMP_TERMINATOR_EN appends the 32'hDEADBEEF end marker after the data.
module uart_ram_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      ram_addr,
    output logic             ram_ren,
    input  logic [31:0]      ram_rdata,
    output logic             uart_tx,
    output logic             busy,
    output logic             done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_DUMP_TERMINATOR_EN
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, TX_START, TX_DATA, TX_STOP, TERM
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, TX_START, TX_DATA, TX_STOP
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        ram_addr_q, ram_addr_d;
    logic               ram_ren_q, ram_ren_d;
    logic               uart_tx_q, uart_tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [31:0]        shift_q, shift_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
`ifdef UART_DUMP_TERMINATOR_EN
    logic               term_q, term_d;
`endif
    logic               baud_end_s;

    assign baud_end_s = (baud_q == BAUD_LAST);

    // Next-state logic; every output is registered, so values are chosen for the state being entered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ram_addr_d  = ram_addr_q;
        ram_ren_d   = 1'b0;
        uart_tx_d   = uart_tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
`ifdef UART_DUMP_TERMINATOR_EN
        term_d      = term_q;
`endif
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the finished dump and is dropped.
                if (start && !done_q) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
`ifdef UART_DUMP_TERMINATOR_EN
                    term_d      = 1'b0;
`endif
                    if (word_count != '0) begin
                        state_d    = RD_REQ;
                        ram_addr_d = base_addr;
                        ram_ren_d  = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
`ifdef UART_DUMP_TERMINATOR_EN
                        state_d = TERM;
                        busy_d  = 1'b1;
`else
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                shift_d    = ram_rdata;
                state_d    = TX_START;
                uart_tx_d  = 1'b0;
                baud_d     = '0;
                byte_idx_d = 2'd0;
            end
            TX_START: begin
                if (baud_end_s) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = TX_DATA;
                    uart_tx_d = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d   = TX_STOP;
                        uart_tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        uart_tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = TX_START;
                        uart_tx_d  = 1'b0;
`ifdef UART_DUMP_TERMINATOR_EN
                    end else if (term_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        // Word boundary: fetch the next word or wrap up the dump.
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q != CNT_W'(1)) begin
                            state_d    = RD_REQ;
                            addr_d     = addr_q + 32'd4;
                            ram_addr_d = addr_q + 32'd4;
                            ram_ren_d  = 1'b1;
                        end else begin
`ifdef UART_DUMP_TERMINATOR_EN
                            state_d = TERM;
`else
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_DUMP_TERMINATOR_EN
            TERM: begin
                shift_d    = 32'hDEAD_BEEF;
                term_d     = 1'b1;
                state_d    = TX_START;
                uart_tx_d  = 1'b0;
                baud_d     = '0;
                byte_idx_d = 2'd0;
            end
`endif
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                uart_tx_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drives the line idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            ram_addr_q  <= 32'd0;
            ram_ren_q   <= 1'b0;
            uart_tx_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            shift_q     <= 32'd0;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
`ifdef UART_DUMP_TERMINATOR_EN
            term_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_ren_q   <= ram_ren_d;
            uart_tx_q   <= uart_tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
`ifdef UART_DUMP_TERMINATOR_EN
            term_q      <= term_d;
`endif
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_ren  = ram_ren_q;
    assign uart_tx  = uart_tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_ram_dumper.sv
// Scoreboard bench for uart_ram_dumper: stimulus queues expected reads, bytes and done cycles;
// independent monitors decode the UART line, RAM strobes and done pulses and compare.
module tb_uart_ram_dumper;

    localparam int CPB = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_addr = 32'd0;
    logic [CW-1:0] word_count = '0;
    logic [31:0]   ram_addr;
    logic          ram_ren;
    logic [31:0]   ram_rdata = 32'd0;
    logic          uart_tx;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } byte_exp_t;

    byte_exp_t   exp_bytes[$];
    logic [31:0] exp_addrs[$];
    int          exp_dones[$];

    uart_ram_dumper #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .ram_addr(ram_addr), .ram_ren(ram_ren),
        .ram_rdata(ram_rdata), .uart_tx(uart_tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0001_0000: ram_word = 32'h1234_5678;
            32'h0001_0004: ram_word = 32'hA1B2_C3D4;
            32'h0001_0008: ram_word = 32'h0F1E_2D3C;
            32'hFFFF_FFFC: ram_word = 32'hCAFE_F00D;
            32'h0000_0000: ram_word = 32'h55AA_33CC;
            default:       ram_word = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // RAM model: data valid the cycle after the strobe
    always @(posedge clk) if (ram_ren) ram_rdata <= ram_word(ram_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s unexpected actual=%h required=none", name, act);
    endtask

    // RAM read monitor
    always @(negedge clk) begin
        if (!rst && ram_ren) begin
            if (exp_addrs.size() == 0) unexpected("ram_addr", ram_addr);
            else check("ram_addr", ram_addr, exp_addrs.pop_front());
        end
    end

    // done monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_dones.size() == 0) unexpected("done_cycle", cyc);
            else check("done_cycle", cyc, exp_dones.pop_front());
            check("busy_at_done", {31'd0, busy}, 32'd0);
        end
    end

    // UART decoder: mid-bit sampling, start/stop width checked at both ends of each bit
    logic       mon_active = 1'b0;
    int         t0 = 0;
    logic [7:0] sh = 8'd0;
    logic       frame_ok = 1'b1;
    int         mon_off;
    assign mon_off = cyc - t0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (uart_tx == 1'b0) begin
                mon_active <= 1'b1;
                t0         <= cyc;
                frame_ok   <= 1'b1;
            end
        end else begin
            if ((mon_off == 1 || mon_off == 3) && uart_tx !== 1'b0) frame_ok <= 1'b0;
            if (mon_off >= 6 && mon_off <= 34 && ((mon_off - 2) % 4) == 0)
                sh[(mon_off - 6) / 4] <= uart_tx;
            if (mon_off == 38 && uart_tx !== 1'b1) frame_ok <= 1'b0;
            if (mon_off == 39) begin
                mon_active <= 1'b0;
                if (exp_bytes.size() == 0) begin
                    unexpected("uart_byte", {24'd0, sh});
                end else begin
                    check("uart_byte", {24'd0, sh}, {24'd0, exp_bytes[0].data});
                    check("byte_start_cycle", t0, exp_bytes[0].at);
                    void'(exp_bytes.pop_front());
                end
                check("framing", {31'd0, frame_ok & (uart_tx === 1'b1)}, 32'd1);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic dump(input logic [31:0] b, input int n);
        int k;
        int s;
        logic [31:0] w;
        logic [31:0] a;
        byte_exp_t e;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = n[CW-1:0];
        k = cyc;
        s = k + 3;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(4 * i);
            exp_addrs.push_back(a);
            w = ram_word(a);
            for (int j = 0; j < 4; j++) begin
                e.data = w[8*j +: 8];
                e.at   = s;
                exp_bytes.push_back(e);
                s += 40;
            end
            if (i != n - 1) s += 2;
        end
        last_done = (n == 0) ? k + 1 : s;
        exp_dones.push_back(last_done);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, {31'd0, (n != 0)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int t_first;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ram_ren", {31'd0, ram_ren}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ram_addr", ram_addr, 32'd0);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || ram_ren !== 1'b0) bad++;
        end
        check("idle_100_cycles", bad, 0);

        // single word, then a start coinciding with done must be ignored
        dump(32'h0001_0000, 1);
        wait_until(last_done);
        start      = 1'b1;
        base_addr  = 32'h0003_0000;
        word_count = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("start_at_done_ignored", {31'd0, busy}, 32'd0);

        dump(32'h0001_0000, 3);
        wait_until(last_done + 2);

        dump(32'hFFFF_FFFC, 2);
        wait_until(last_done + 2);

        // start while busy is ignored; then an empty dump
        dump(32'h0001_0000, 3);
        wait_until(cyc + 50);
        start      = 1'b1;
        base_addr  = 32'h0002_0000;
        word_count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_dump", {31'd0, busy}, 32'd1);
        wait_until(last_done + 2);
        dump(32'h0004_0000, 0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_dump_quiet", bad, 0);

        // reset during the first data bit (byte 0x78, bit0 = 0)
        dump(32'h0001_0000, 1);
        t_first = last_done - 160;
        wait_until(t_first + 5);
        check("tx_low_before_reset", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("reset_mid_bit_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_mid_bit_busy", {31'd0, busy}, 32'd0);
        exp_bytes.delete();
        exp_dones.delete();
        exp_addrs.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        dump(32'h0001_0008, 1);
        wait_until(last_done + 3);

        check("pending_bytes", exp_bytes.size(), 0);
        check("pending_addrs", exp_addrs.size(), 0);
        check("pending_dones", exp_dones.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
